histogram_accum_engine: RTL
===========================

HISTOGRAM_ACCUM_ENGINE -- requirements
Module: histogram_accum_engine

Interface
REQ-001 Parameter PIX_W, default 8, pixel width; the bin count BINS SHALL be 2**PIX_W.
REQ-002 Parameter LANES, default 2, pixels accepted per beat (1..8).
REQ-003 Parameter CNT_W, default 16, width of each bin counter and of each output count.
REQ-004 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 SHALL force reset state immediately.
REQ-006 start  in  1  begin a new histogram; sampled only in IDLE.
REQ-007 cdf_mode  in  1  0 selects raw histogram readout, 1 selects cumulative (CDF) readout; latched on accepted start.
REQ-008 pix_valid  in  1  pixel beat valid.
REQ-009 pix_ready  out  1  engine accepts a beat.
REQ-010 pix_data  in  LANES*PIX_W  lane k at bits [k*PIX_W +: PIX_W].
REQ-011 pix_last  in  1  marks the final beat of the image.
REQ-012 out_valid  out  1  readout word valid.
REQ-013 out_ready  in  1  downstream accepts the readout word.
REQ-014 out_bin  out  PIX_W  bin index of the current word.
REQ-015 out_count  out  CNT_W  raw or cumulative count for out_bin.
REQ-016 out_last  out  1  high with bin BINS-1.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at completion.
REQ-019 overflow  out  1  sticky saturation flag; cleared on accepted start.

Function
REQ-020 FSM states SHALL be IDLE, CLEAR, ACCUM, READOUT, DONE.
REQ-021 IDLE -> CLEAR on start=1; start in any other state SHALL be ignored.
REQ-022 CLEAR SHALL zero all BINS counters in one cycle, then go to ACCUM.
REQ-023 pix_ready SHALL be 1 only in ACCUM; a beat is accepted when pix_valid & pix_ready.
REQ-024 An accepted beat SHALL add to each bin the number of lanes whose value equals that bin, so same-bin lanes in one beat all count (e.g. {5,5} adds 2 to bin 5).
REQ-025 Counter update SHALL be visible at the next edge; back-to-back beats SHALL accumulate without stalls or lost counts.
REQ-026 Counters SHALL saturate at 2**CNT_W-1; any clipped increment SHALL set overflow.
REQ-027 An accepted beat with pix_last=1 SHALL be counted, and the FSM SHALL go to READOUT the next cycle.
REQ-028 In READOUT, out_valid SHALL be 1 from the first cycle, with out_bin starting at 0 and incrementing by 1 on each out_valid & out_ready.
REQ-029 While out_valid=1 and out_ready=0, out_bin, out_count and out_last SHALL stay stable.
REQ-030 In raw mode, out_count SHALL equal counter[out_bin].
REQ-031 In CDF mode, out_count SHALL equal the sum of counters[0..out_bin], saturating at 2**CNT_W-1; saturation SHALL set overflow.
REQ-032 The handshake on out_last SHALL move the FSM to DONE; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-033 A readout word SHALL hold out_valid=0 outside READOUT; out_bin and out_count SHALL be 0 then.

Reset
REQ-034 reset=0 SHALL set state=IDLE, with pix_ready=0, out_valid=0, out_bin=0, out_count=0, out_last=0, busy=0, done=0, overflow=0, and cdf_mode latch=0.
REQ-035 Counter contents need not reset; CLEAR SHALL guarantee no residue from an aborted run.

Verification (PIX_W=8, LANES=2, CNT_W=16 unless noted)
REQ-036 Assert reset=0 mid-ACCUM -> all outputs at REQ-034 values in the same cycle, busy=0.
REQ-037 Raw mode, beats {5,5} then {5,200} with pix_last -> 256 words: bin5=3, bin200=1, all others 0, out_last only at bin 255, then a done pulse.
REQ-038 Repeat REQ-037 with cdf_mode=1 -> bins 0-4=0, bins 5-199=3, bins 200-255=4.
REQ-039 Hold out_ready=0 for 3 cycles at bin 7 -> out_bin=7 and out_count stay constant, and no bin is skipped.
REQ-040 With CNT_W=4, send 9 beats of {1,1} -> bin1=15, overflow=1, other bins 0.
REQ-041 Reset during READOUT, then start and one beat {9,9} with pix_last -> bin9=2, all others 0, with no residue from the aborted run.

Source files
------------

// File: rtl/histogram_accum_engine.sv
// Multi-lane pixel histogram engine: clears BINS counters, accumulates
// LANES pixels per beat with saturation, then streams raw or cumulative counts.
module histogram_accum_engine #(
  parameter int PIX_W = 8,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   cdf_mode,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [LANES*PIX_W-1:0] pix_data,
  input  logic                   pix_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIX_W-1:0]       out_bin,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int BINS  = 2 ** PIX_W;
  localparam int INC_W = 4;
  localparam int SUM_W = CNT_W + INC_W;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    READOUT,
    DONE
  } state_t;

  state_t           state;
  logic             cdf_q;
  logic [CNT_W-1:0] cdf_acc;

  logic [CNT_W-1:0] cnt      [BINS];
  logic [CNT_W-1:0] cnt_next [BINS];
  logic [BINS-1:0]  sat_hit;

  logic             beat;
  logic [CNT_W-1:0] raw_word;
  logic [CNT_W:0]   cdf_sum;
  logic [CNT_W-1:0] cdf_word;
  logic             cdf_sat;

  assign beat = pix_valid & pix_ready;

  // Every bin counts how many lanes hit it, so duplicate lanes in one beat all land.
  always_comb begin
    sat_hit = '0;
    for (int unsigned b = 0; b < BINS; b++) begin : g_bin
      logic [INC_W-1:0] inc;
      logic [SUM_W-1:0] sum;
      inc = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        if (pix_data[k*PIX_W +: PIX_W] == PIX_W'(b)) inc = inc + 1'b1;
      end
      sum = SUM_W'(cnt[b]) + SUM_W'(inc);
      if (sum[SUM_W-1:CNT_W] != '0) begin
        cnt_next[b] = '1;
        sat_hit[b]  = 1'b1;
      end else begin
        cnt_next[b] = sum[CNT_W-1:0];
      end
    end
  end

  // Counters carry no reset; CLEAR wipes any residue before accumulation.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      for (int unsigned b = 0; b < BINS; b++) cnt[b] <= '0;
    end else if (beat) begin
      for (int unsigned b = 0; b < BINS; b++) cnt[b] <= cnt_next[b];
    end
  end

  // cdf_acc holds the prefix sum of bins below out_bin; current bin is added on the fly.
  assign raw_word = cnt[out_bin];
  assign cdf_sum  = {1'b0, cdf_acc} + {1'b0, raw_word};
  assign cdf_sat  = cdf_sum[CNT_W];
  assign cdf_word = cdf_sat ? '1 : cdf_sum[CNT_W-1:0];
  assign out_count = out_valid ? (cdf_q ? cdf_word : raw_word) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cdf_q     <= 1'b0;
      cdf_acc   <= '0;
      pix_ready <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            cdf_q    <= cdf_mode;
            overflow <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          state     <= ACCUM;
          pix_ready <= 1'b1;
        end
        ACCUM: begin
          if (beat) begin
            if (|sat_hit) overflow <= 1'b1;
            if (pix_last) begin
              state     <= READOUT;
              pix_ready <= 1'b0;
              out_valid <= 1'b1;
              out_bin   <= '0;
              out_last  <= 1'b0;
              cdf_acc   <= '0;
            end
          end
        end
        READOUT: begin
          if (cdf_q && cdf_sat) overflow <= 1'b1;
          if (out_ready) begin
            if (out_last) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_bin   <= '0;
              cdf_acc   <= '0;
              done      <= 1'b1;
            end else begin
              out_bin  <= out_bin + 1'b1;
              out_last <= (out_bin == PIX_W'(BINS - 2));
              cdf_acc  <= cdf_word;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
